// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions: polynomial, default constants, FSM state type and the
// parallel 8-bit update step (MSB-first, data bit 7 enters first).
package crc32_pkg;

  localparam logic [31:0] POLY        = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR_OUT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [1:0] {IDLE, RUN, DONE} crc_state_t;

  // One byte folded into the register, unrolled by synthesis into an XOR network.
  function automatic logic [31:0] crc32_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_fold4.sv
// Combinational four-byte CRC chain; exposes every intermediate step so the
// parent can pick the result for a partial last word.
module crc32_fold4
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc1,
  output logic [31:0] crc2,
  output logic [31:0] crc3,
  output logic [31:0] crc4
);

  assign crc1 = crc32_d8(data[31:24], crc_in);
  assign crc2 = crc32_d8(data[23:16], crc1);
  assign crc3 = crc32_d8(data[15:8],  crc2);
  assign crc4 = crc32_d8(data[7:0],   crc3);

endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer for the CRC-32 byte engine: seeds, folds up to four bytes per
// beat, counts bytes and holds the final CRC / residue flag for a result handshake.
module crc32_frame_ctrl
  import crc32_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter logic [31:0] INIT    = CRC_INIT,
  parameter logic [31:0] XOR_OUT = CRC_XOR_OUT,
  parameter logic [31:0] RESIDUE = CRC_RESIDUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  input  logic [1:0]       s_nbytes,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      crc_out,
  output logic             crc_ok,
  output logic [LEN_W-1:0] frame_len
);

  localparam int unsigned SUM_W = LEN_W + 1;

  crc_state_t       r_state;
  logic [31:0]      r_crc;
  logic [LEN_W-1:0] r_len;
  logic             r_s_ready;
  logic             r_res_valid;
  logic [31:0]      r_crc_out;
  logic             r_crc_ok;
  logic [LEN_W-1:0] r_frame_len;

  logic [31:0]      w_crc1, w_crc2, w_crc3, w_crc4;
  logic [31:0]      w_crc_sel;
  logic [2:0]       w_n;
  logic [SUM_W-1:0] w_len_sum;
  logic [LEN_W-1:0] w_len_next;
  logic             w_accept;

  crc32_fold4 u_fold (
    .crc_in (r_crc),
    .data   (s_data),
    .crc1   (w_crc1),
    .crc2   (w_crc2),
    .crc3   (w_crc3),
    .crc4   (w_crc4)
  );

  // Byte count of this beat: full word unless a last beat names 1..3 bytes.
  assign w_n = (s_last && (s_nbytes != 2'd0)) ? {1'b0, s_nbytes} : 3'd4;

  always_comb begin
    w_crc_sel = w_crc4;
    case (w_n)
      3'd1:    w_crc_sel = w_crc1;
      3'd2:    w_crc_sel = w_crc2;
      3'd3:    w_crc_sel = w_crc3;
      default: w_crc_sel = w_crc4;
    endcase
  end

  assign w_len_sum  = {1'b0, r_len} + SUM_W'(w_n);
  assign w_len_next = w_len_sum[LEN_W] ? {LEN_W{1'b1}} : w_len_sum[LEN_W-1:0];
  assign w_accept   = s_valid && r_s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_len       <= '0;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_crc_out   <= '0;
      r_crc_ok    <= 1'b0;
      r_frame_len <= '0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_len       <= '0;
      r_s_ready   <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_crc <= w_crc_sel;
            r_len <= w_len_next;
            if (s_last) begin
              r_state     <= DONE;
              r_s_ready   <= 1'b0;
              r_res_valid <= 1'b1;
              r_crc_out   <= w_crc_sel ^ XOR_OUT;
              r_crc_ok    <= (w_crc_sel == RESIDUE);
              r_frame_len <= w_len_next;
            end else begin
              r_state <= RUN;
            end
          end
        end
        DONE: begin
          // Input stays closed through the handshake cycle; reopen on the next one.
          if (res_ready) begin
            r_state     <= IDLE;
            r_crc       <= INIT;
            r_len       <= '0;
            r_s_ready   <= 1'b1;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_crc     <= INIT;
          r_len     <= '0;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign res_valid = r_res_valid;
  assign crc_out   = r_crc_out;
  assign crc_ok    = r_crc_ok;
  assign frame_len = r_frame_len;

endmodule
